// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential 32-bit restoring divider, signed and unsigned
module div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        stallreq_o
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [64:0] work;      // {partial remainder, dividend shifting into quotient}
   logic [31:0] divisor;
   logic        neg_quo;   // captured at start so later input changes cannot alter the fix-up
   logic        neg_rem;

   logic        op1_neg;
   logic        op2_neg;
   logic [31:0] op1_mag;
   logic [31:0] op2_mag;
   logic [64:0] shifted;
   logic [32:0] diff;
   logic [64:0] step_next;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // Operand magnitudes, one radix-2 restoring step and the final sign fix-up
   always_comb begin
      op1_neg   = signed_div_i & opdata1_i[31];
      op2_neg   = signed_div_i & opdata2_i[31];
      op1_mag   = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
      op2_mag   = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;
      shifted   = work << 1;
      diff      = shifted[64:32] - {1'b0, divisor};
      step_next = shifted;
      if (!diff[32]) begin
         step_next = {diff, shifted[31:0] | 32'd1};
      end
      quo_fix   = neg_quo ? (~work[31:0] + 32'd1) : work[31:0];
      rem_fix   = neg_rem ? (~work[63:32] + 32'd1) : work[63:32];
   end

   // The stall must drop in the same cycle ready_o rises, so it stays combinational
   assign stallreq_o = start_i & ~annul_i & ~ready_o;

   // Divider FSM with registered result and ready
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FREE;
         cnt      <= 6'd0;
         work     <= 65'd0;
         divisor  <= 32'd0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         result_o <= 64'd0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               ready_o  <= 1'b0;
               result_o <= 64'd0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == 32'd0) begin
                     state <= BYZERO;
                  end else begin
                     state   <= ON;
                     cnt     <= 6'd0;
                     work    <= {33'd0, op1_mag};
                     divisor <= op2_mag;
                     neg_quo <= op1_neg ^ op2_neg;
                     neg_rem <= op1_neg;
                  end
               end
            end
            BYZERO: begin
               if (annul_i) begin
                  state <= FREE;
               end else begin
                  state    <= END;
                  result_o <= 64'd0;
                  ready_o  <= 1'b1;
               end
            end
            ON: begin
               if (annul_i) begin
                  state <= FREE;
                  cnt   <= 6'd0;
               end else if (cnt == 6'd32) begin
                  state    <= END;
                  result_o <= {rem_fix, quo_fix};
                  ready_o  <= 1'b1;
               end else begin
                  work <= step_next;
                  cnt  <= cnt + 6'd1;
               end
            end
            END: begin
               // annul_i is deliberately ignored here; only dropping start_i releases the result
               if (!start_i) begin
                  state    <= FREE;
                  result_o <= 64'd0;
                  ready_o  <= 1'b0;
               end
            end
            default: state <= FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking scoreboard bench for div_seq
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stallreq;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   div_seq dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (opdata1),
      .opdata2_i    (opdata2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready),
      .stallreq_o   (stallreq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] qv, rv;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit scramble, input int hold);
      int edges;
      int stalls;
      int lat;
      logic [63:0] exp;
      @(posedge clk); #1;
      signed_div = sgn;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      exp_q.push_back(model(sgn, a, b));
      edges  = 0;
      stalls = 0;
      while (!ready && edges < 100) begin
         @(negedge clk);
         if (stallreq) stalls++;
         @(posedge clk); #1;
         edges++;
         if (scramble) begin
            opdata1 = $urandom;
            opdata2 = $urandom;
         end
      end
      lat = (b == 32'd0) ? 2 : 34;
      chk({tag, "_latency"}, edges, lat);
      chk({tag, "_stall_cycles"}, stalls, lat);
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 64'd1, 64'd0);
      end else begin
         exp = exp_q.pop_front();
         chk({tag, "_result"}, result, exp);
         for (int i = 0; i < hold; i++) begin
            annul = (i % 2 == 0);
            @(posedge clk); #1;
            chk({tag, "_hold_result"}, result, exp);
            chk({tag, "_hold_ready"}, ready, 1'b1);
         end
      end
      annul = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_drop_ready"}, ready, 1'b0);
      chk({tag, "_drop_result"}, result, 64'd0);
   endtask

   initial begin
      int seen;
      rst        = 1'b1;
      signed_div = 1'b0;
      opdata1    = 32'd0;
      opdata2    = 32'd0;
      start      = 1'b0;
      annul      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_result", result, 64'd0);
      chk("rst_ready", ready, 1'b0);
      chk("rst_stall", stallreq, 1'b0);
      rst = 1'b0;

      run_div("u100_7", 1'b0, 32'd100, 32'd7, 1'b0, 0);
      chk("u100_7_const", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
      run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
      run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
      run_div("s_div0", 1'b1, 32'h12345678, 32'd0, 1'b0, 0);
      run_div("u_div0", 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 0);
      run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, 0);

      // annul mid-ON: FFFFFFFF / 1, cancelled at edge 10
      @(posedge clk); #1;
      signed_div = 1'b0;
      opdata1    = 32'hFFFFFFFF;
      opdata2    = 32'd1;
      start      = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      annul = 1'b1;
      @(negedge clk);
      chk("annul_stall", stallreq, 1'b0);
      @(posedge clk); #1;
      annul = 1'b0;
      start = 1'b0;
      seen  = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready) seen++;
      end
      chk("annul_no_ready", seen, 0);
      run_div("u9_3", 1'b0, 32'd9, 32'd3, 1'b0, 0);

      // operands changing during ON must not matter
      run_div("scr_s", 1'b1, 32'h9ABCDEF0, 32'h00012345, 1'b1, 0);
      run_div("scr_u", 1'b0, 32'hDEADBEEF, 32'h00000013, 1'b1, 0);

      // hold start past ready, with annul toggled in END
      run_div("hold5", 1'b1, 32'd1000, 32'hFFFFFFFD, 1'b0, 5);

      // start and annul together in FREE: nothing begins
      @(posedge clk); #1;
      opdata1 = 32'd50;
      opdata2 = 32'd5;
      start   = 1'b1;
      annul   = 1'b1;
      seen    = 0;
      repeat (5) begin
         @(negedge clk);
         if (ready || stallreq) seen++;
      end
      chk("start_annul_free", seen, 0);
      start = 1'b0;
      annul = 1'b0;

      // reset at cnt=20 (cnt reaches 20 after edge 21)
      @(posedge clk); #1;
      signed_div = 1'b0;
      opdata1    = 32'd1000;
      opdata2    = 32'd3;
      start      = 1'b1;
      repeat (21) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_result", result, 64'd0);
      chk("midrst_ready", ready, 1'b0);
      @(negedge clk);
      chk("midrst_stall", stallreq, 1'b1);
      rst   = 1'b0;
      start = 1'b0;
      seen  = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready) seen++;
      end
      chk("midrst_no_ready", seen, 0);
      run_div("after_rst", 1'b0, 32'd1000, 32'd3, 1'b0, 0);

      for (int k = 0; k < 6; k++) begin
         run_div("rand", k[0], $urandom, $urandom >> (k * 5), 1'b0, 0);
      end

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
